// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way memory port arbiter.
// Imported by the arbiter top and its round-robin pick sub-module.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    typedef logic [1:0] req_idx_t;

    function automatic logic [NUM_REQ-1:0] onehot(input req_idx_t idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotate-priority encoder: first asserted request searching upward from last+1, mod 4.
// Purely combinational; valid is low when no request is asserted.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output req_idx_t           idx,
    output logic               valid
);

    req_idx_t cand;

    // Scan the farthest offset first so the nearest requester after 'last' is written last and wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = req_idx_t'(int'(last) + k);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter4.sv
// Round-robin arbiter sharing one memory port among four requesters, with a
// registered grant/select/strobe set and an optional BUSY watchdog.
module mem_arbiter4
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_write,
    input  logic               mem_resp,
    output logic [1:0]         sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               mem_read,
    output logic               mem_write,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               timeout
);

    // Width is derived from TIMEOUT; a disabled watchdog still keeps a 1-bit counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t         state_q, state_d;
    req_idx_t           last_q, last_d;
    req_idx_t           sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               timeout_q, timeout_d;

    req_idx_t           pick_idx;
    logic               pick_valid;
    logic               wd_expire;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign wd_expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    sel_d   = pick_idx;
                    grant_d = onehot(pick_idx);
                    wr_d    = req_write[pick_idx];
                    rd_d    = ~req_write[pick_idx];
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the expiry cycle completes normally; the watchdog only fires without one.
                if (mem_resp || wd_expire) begin
                    state_d   = IDLE;
                    last_d    = sel_q;
                    sel_d     = '0;
                    grant_d   = '0;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    timeout_d = ~mem_resp;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                grant_d = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // Reset pointer of 3 gives requester 0 first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q   <= IDLE;
            last_q    <= 2'd3;
            sel_q     <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign busy      = (state_q == BUSY);
    assign timeout   = timeout_q;
    assign done      = grant_q & {NUM_REQ{mem_resp}};

endmodule

// File: tb/tb_mem_arbiter4.sv
// Self-checking bench: two arbiters (TIMEOUT 8 and 4) driven by directed and random
// transactions, checked against a transaction-level round-robin model.
module tb_mem_arbiter4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req       [2];
    logic [3:0] req_write [2];
    logic       mem_resp  [2];
    logic [1:0] sel_o     [2];
    logic [3:0] grant_o   [2];
    logic       rd_o      [2];
    logic       wr_o      [2];
    logic [3:0] done_o    [2];
    logic       busy_o    [2];
    logic       tmo_o     [2];

    int n_tests = 0;
    int n_fail  = 0;
    int m_last [2];
    int to_cyc [2] = '{8, 4};

    always #5 clk = ~clk;

    mem_arbiter4 #(.TIMEOUT(8)) u_dut_a (
        .clk(clk), .reset(reset), .req(req[0]), .req_write(req_write[0]),
        .mem_resp(mem_resp[0]), .sel(sel_o[0]), .grant(grant_o[0]),
        .mem_read(rd_o[0]), .mem_write(wr_o[0]), .done(done_o[0]),
        .busy(busy_o[0]), .timeout(tmo_o[0])
    );

    mem_arbiter4 #(.TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset), .req(req[1]), .req_write(req_write[1]),
        .mem_resp(mem_resp[1]), .sel(sel_o[1]), .grant(grant_o[1]),
        .mem_read(rd_o[1]), .mem_write(wr_o[1]), .done(done_o[1]),
        .busy(busy_o[1]), .timeout(tmo_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference pick: nearest asserted requester after the last one served.
    function automatic int pick(input logic [3:0] rv, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (rv[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic check_idle(input int d, input string tag);
        check({tag, "_busy"},  busy_o[d],  0);
        check({tag, "_grant"}, grant_o[d], 0);
        check({tag, "_sel"},   sel_o[d],   0);
        check({tag, "_rd"},    rd_o[d],    0);
        check({tag, "_wr"},    wr_o[d],    0);
    endtask

    // Called at a negedge with DUT d idle. resp_at = BUSY cycle carrying mem_resp, 0 = never.
    task automatic txn(input int d, input logic [3:0] rv, input logic [3:0] wv, input int resp_at);
        int         exp_idx;
        logic       exp_w;
        logic [3:0] g;
        exp_idx = pick(rv, m_last[d]);
        exp_w   = wv[exp_idx];
        g       = 4'b0001 << exp_idx;
        req[d]       = rv;
        req_write[d] = wv;
        @(negedge clk);
        for (int c = 1; c <= to_cyc[d]; c++) begin
            check("grant", grant_o[d], g);
            check("sel",   sel_o[d],   exp_idx);
            check("busy",  busy_o[d],  1);
            check("rd",    rd_o[d],    !exp_w);
            check("wr",    wr_o[d],    exp_w);
            check("tmo_in_busy", tmo_o[d], 0);
            req_write[d] = ~wv;
            req[d]       = 4'($urandom);
            if (c == resp_at) mem_resp[d] = 1'b1;
            #1;
            check("done", done_o[d], (c == resp_at) ? g : 4'b0000);
            @(negedge clk);
            mem_resp[d] = 1'b0;
            if (c == resp_at) break;
        end
        req[d]       = '0;
        req_write[d] = '0;
        check_idle(d, "after");
        check("done_after", done_o[d], 0);
        check("timeout", tmo_o[d], (resp_at == 0) ? 1 : 0);
        m_last[d] = exp_idx;
    endtask

    initial begin
        #500000;
        $display("FAIL sim_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; req_write[d] = '0; mem_resp[d] = 1'b0; m_last[d] = 3;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "reset");
            check("reset_tmo", tmo_o[d], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Spurious response while idle.
        mem_resp[0] = 1'b1;
        #1 check("spurious_done", done_o[0], 0);
        @(negedge clk);
        mem_resp[0] = 1'b0;
        check_idle(0, "spurious");

        // Round robin with all requests held: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) txn(0, 4'b1111, 4'b0000, 2);

        // Single read on requester 2.
        txn(0, 4'b0100, 4'b0000, 3);

        // Write capture with req_write flipped while busy.
        txn(0, 4'b0010, 4'b0010, 3);

        // Watchdog abort then next pick.
        txn(0, 4'b0001, 4'b0000, 0);
        txn(0, 4'b0011, 4'b0000, 2);

        // Response and watchdog expiry in the same cycle.
        txn(1, 4'b0100, 4'b0100, 4);
        txn(1, 4'b1000, 4'b0000, 0);

        // Async reset mid-read.
        req[0] = 4'b0001; req_write[0] = 4'b0000;
        @(negedge clk);
        req[0] = '0;
        check("pre_reset_rd", rd_o[0], 1);
        #2 reset = 1'b1;
        #1;
        check("arst_rd",    rd_o[0],    0);
        check("arst_grant", grant_o[0], 0);
        check("arst_busy",  busy_o[0],  0);
        @(negedge clk);
        reset = 1'b0;
        m_last[0] = 3;
        m_last[1] = 3;
        txn(0, 4'b1001, 4'b0000, 2);

        // Random traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            int d;
            int ra;
            d  = int'($urandom_range(0, 1));
            ra = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, to_cyc[d]));
            txn(d, 4'($urandom_range(1, 15)), 4'($urandom), ra);
            if ($urandom_range(0, 2) == 0) begin
                mem_resp[d] = 1'($urandom);
                #1 check("rand_idle_done", done_o[d], 0);
                @(negedge clk);
                mem_resp[d] = 1'b0;
                check_idle(d, "rand_idle");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
